// File: rtl/drum_mul_sched.sv
// Two-requester scheduler in front of a shared fixed-latency multiplier.
// Grants alternate under contention, and each accepted operation is held until its product has been handed off.
module drum_mul_sched #(
    parameter int N       = 8,
    parameter int M       = 8,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [M-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [M-1:0]     req1_b,
    output logic [N-1:0]     mul_a,
    output logic [M-1:0]     mul_b,
    input  logic [N+M-1:0]   mul_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [N+M-1:0]   rsp_data,
    output logic             busy
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic              last_grant_reg;
    logic [N-1:0]      a_reg;
    logic [M-1:0]      b_reg;
    logic [N+M-1:0]    rsp_data_reg;
    logic              rsp_id_reg;
    logic              grant_id;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Readies are also gated by rst_n: during reset the FSM sits in IDLE,
    // but nothing may be granted until rst_n is released.
    always_comb begin
        state_next = state_reg;
        grant_id   = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                grant_id   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
                accept     = rst_n && ena && (req0_valid || req1_valid);
                req0_ready = accept && !grant_id;
                req1_ready = accept && grant_id;
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            rsp_data_reg   <= '0;
            rsp_id_reg     <= 1'b0;
        end else if (accept) begin
            a_reg          <= grant_id ? req1_a : req0_a;
            b_reg          <= grant_id ? req1_b : req0_b;
            rsp_id_reg     <= grant_id;
            last_grant_reg <= grant_id;
            cnt_reg        <= CW'(MUL_LAT - 1);
        end else if (state_reg == WAIT) begin
            if (cnt_reg == '0) begin
                rsp_data_reg <= mul_r;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign mul_a    = a_reg;
    assign mul_b    = b_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_id   = rsp_id_reg;

endmodule

// File: tb/tb_drum_mul_sched.sv
// Bench for drum_mul_sched with N=M=4, MUL_LAT=2 and an exact multiplier on mul_r.
// Directed scenarios followed by a randomized run against a transaction-timing reference model.
module tb_drum_mul_sched;

    localparam int N   = 4;
    localparam int M   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           req0_valid, req0_ready;
    logic [N-1:0]   req0_a;
    logic [M-1:0]   req0_b;
    logic           req1_valid, req1_ready;
    logic [N-1:0]   req1_a;
    logic [M-1:0]   req1_b;
    logic [N-1:0]   mul_a;
    logic [M-1:0]   mul_b;
    logic [N+M-1:0] mul_r;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [N+M-1:0] rsp_data;
    logic           busy;

    int vectors    = 0;
    int miscompares = 0;

    drum_mul_sched #(.N(N), .M(M), .MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_r      (mul_r),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign mul_r = {4'b0, mul_a} * {4'b0, mul_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ena        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b1;
    endtask

    task automatic pulse_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ena        = 1'($urandom);
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a     = 4'($urandom);
            req0_b     = 4'($urandom);
            req1_a     = 4'($urandom);
            req1_b     = 4'($urandom);
            rsp_ready  = 1'($urandom);
            tick();
            obs = {req0_ready, req1_ready, rsp_valid, busy, rsp_id, mul_a, mul_b, rsp_data};
            vectors++;
            if (obs !== 21'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
            end
        end
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive_idle();
        req0_valid = 1'b1;
        req0_a     = 4'd3;
        req0_b     = 4'd2;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        vectors++;
        if ({busy, rsp_valid, mul_a, mul_b} !== {1'b1, 1'b0, 4'd3, 4'd2}) begin
            miscompares++;
            $display("FAIL single_wait: got %b expected 10_0011_0010", {busy, rsp_valid, mul_a, mul_b});
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_rsp: got %b expected 0", rsp_valid);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'd6}) begin
            miscompares++;
            $display("FAIL single_rsp: valid %b id %b data %0d expected 1 0 6", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_done: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_contention();
        int acc0 = -1;
        int acc1 = -1;
        int rid[2] = '{-1, -1};
        int rdat[2] = '{-1, -1};
        int nrsp = 0;
        logic got0, got1;
        pulse_reset();
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            got0 = req0_valid && req0_ready;
            got1 = req1_valid && req1_ready;
            if (got0) acc0 = cyc;
            if (got1) acc1 = cyc;
            if (rsp_valid && rsp_ready && nrsp < 2) begin
                rid[nrsp]  = int'(rsp_id);
                rdat[nrsp] = int'(rsp_data);
                nrsp++;
            end
            tick();
            if (got0) req0_valid = 1'b0;
            if (got1) req1_valid = 1'b0;
        end
        vectors++;
        if (rid[0] != 0 || rdat[0] != 2) begin
            miscompares++;
            $display("FAIL contention_first: id %0d data %0d expected id 0 data 2", rid[0], rdat[0]);
        end
        vectors++;
        if (rid[1] != 1 || rdat[1] != 15) begin
            miscompares++;
            $display("FAIL contention_second: id %0d data %0d expected id 1 data 15", rid[1], rdat[1]);
        end
        vectors++;
        if (acc0 < 0 || acc1 - acc0 != LAT + 2) begin
            miscompares++;
            $display("FAIL contention_spacing: accepts at %0d and %0d expected spacing %0d", acc0, acc1, LAT + 2);
        end
    endtask

    task automatic test_backpressure();
        drive_idle();
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        tick();
        for (int i = 0; i < LAT + 5; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            if (i >= LAT) begin
                #1;
                vectors++;
                if ({rsp_valid, rsp_id, rsp_data, mul_a, mul_b, req0_ready, req1_ready} !==
                    {1'b1, 1'b1, 8'd63, 4'd7, 4'd9, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL bp_hold cycle %0d: valid %b id %b data %0d a %0d b %0d rdy %b%b expected 1 1 63 7 9 00",
                             i, rsp_valid, rsp_id, rsp_data, mul_a, mul_b, req0_ready, req1_ready);
                end
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: busy %b expected 0", busy);
        end
    endtask

    task automatic test_enable();
        int waited = 0;
        drive_idle();
        ena = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({req1_ready, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL ena_block cycle %0d: ready/busy %b expected 00", i, {req1_ready, busy});
            end
            tick();
        end
        ena = 1'b1;
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ena_grant: req1_ready %b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        ena = 1'b0;
        #1;
        vectors++;
        if ({busy, mul_a} !== {1'b1, 4'd4}) begin
            miscompares++;
            $display("FAIL ena_accept: busy %b mul_a %0d expected 1 4", busy, mul_a);
        end
        while (rsp_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'd16) begin
            miscompares++;
            $display("FAIL ena_complete: valid %b id %b data %0d expected 1 1 16", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        ena = 1'b1;
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        drive_idle();
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        tick();
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, rsp_valid, mul_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_abort: busy %b valid %b mul_a %0d expected 0 0 0", busy, rsp_valid, mul_a);
        end
        tick();
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_first_grant: req1_ready %b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        while (rsp_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'd25) begin
            miscompares++;
            $display("FAIL midreset_next: valid %b id %b data %0d expected 1 1 25", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    // Reference: an operation occupies the unit from its accept edge until the
    // response handshake; the response is offered from LAT edges after accept.
    task automatic test_random();
        logic       pv[2];
        logic [3:0] pa[2], pb[2];
        logic       m_busy, m_id, m_last;
        logic [3:0] m_a, m_b;
        int         since;
        logic       e_any, e_g, e_rv;
        logic [7:0] e_prod;
        pulse_reset();
        pv = '{1'b0, 1'b0};
        pa = '{4'd0, 4'd0};
        pb = '{4'd0, 4'd0};
        m_busy = 1'b0; m_id = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; since = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(2) == 0) begin
                    pv[r] = 1'b1;
                    pa[r] = 4'($urandom);
                    pb[r] = 4'($urandom);
                end
            end
            ena        = ($urandom_range(4) != 0);
            rsp_ready  = 1'($urandom);
            req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0];
            req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1];
            #1;
            e_any  = !m_busy && ena && (pv[0] || pv[1]);
            e_g    = (pv[0] && pv[1]) ? !m_last : pv[1];
            e_rv   = m_busy && (since >= LAT);
            e_prod = {4'b0, m_a} * {4'b0, m_b};
            vectors++;
            if ({req0_ready, req1_ready} !== {e_any && !e_g, e_any && e_g}) begin
                miscompares++;
                $display("FAIL rand_ready cycle %0d: got %b expected %b", cyc,
                         {req0_ready, req1_ready}, {e_any && !e_g, e_any && e_g});
            end
            vectors++;
            if ({busy, rsp_valid} !== {m_busy, e_rv}) begin
                miscompares++;
                $display("FAIL rand_status cycle %0d: busy/valid %b expected %b", cyc,
                         {busy, rsp_valid}, {m_busy, e_rv});
            end
            if (m_busy) begin
                vectors++;
                if ({mul_a, mul_b} !== {m_a, m_b}) begin
                    miscompares++;
                    $display("FAIL rand_operands cycle %0d: got %h expected %h", cyc, {mul_a, mul_b}, {m_a, m_b});
                end
            end
            if (e_rv) begin
                vectors++;
                if ({rsp_id, rsp_data} !== {m_id, e_prod}) begin
                    miscompares++;
                    $display("FAIL rand_rsp cycle %0d: id %b data %0d expected id %b data %0d",
                             cyc, rsp_id, rsp_data, m_id, e_prod);
                end
            end
            if (e_any) begin
                m_busy = 1'b1;
                since  = 0;
                m_id   = e_g;
                m_last = e_g;
                m_a    = pa[e_g];
                m_b    = pb[e_g];
                pv[e_g] = 1'b0;
            end else if (m_busy) begin
                if (e_rv && rsp_ready) m_busy = 1'b0;
                else if (since < LAT) since++;
            end
            tick();
        end
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drum_mul_sched.md
DRUM_MUL_SCHED -- requirements
Module: drum_mul_sched

Interface
REQ-001 SHALL have parameter N, default 8: width of operand A.
REQ-002 SHALL have parameter M, default 8: width of operand B.
REQ-003 SHALL have parameter MUL_LAT, default 1, legal range 1..15: number of clock cycles the shared multiplier needs before mul_r is valid.
REQ-004 SHALL have port clk, input, 1 bit: single clock; every flop is clocked on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ena, input, 1 bit: when high, new requests may be granted.
REQ-007 SHALL have ports req0_valid (input, 1), req0_ready (output, 1), req0_a (input, N) and req0_b (input, M): requester 0.
REQ-008 SHALL have ports req1_valid (input, 1), req1_ready (output, 1), req1_a (input, N) and req1_b (input, M): requester 1.
REQ-009 SHALL have ports mul_a (output, N) and mul_b (output, M): operands driven to the shared multiplier.
REQ-010 SHALL have port mul_r, input, N+M bits: product returned by the shared multiplier.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1) and rsp_data (output, N+M): response channel.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 In IDLE with ena=1, grant SHALL be decided combinationally:
- only one requester valid: that requester is granted;
- both valid: the requester not equal to last_grant is granted.
REQ-015 reqX_ready SHALL be 1 only when state=IDLE, ena=1 and requester X is granted; the other ready SHALL be 0.
REQ-016 On a rising edge with reqX_valid and reqX_ready both high, the block SHALL:
- capture reqX_a and reqX_b into the operand registers;
- set rsp_id to X and last_grant to X;
- load the counter with MUL_LAT-1;
- go to WAIT.
REQ-017 mul_a and mul_b SHALL be driven only from the operand registers, and SHALL hold their value through WAIT, RESP and the following IDLE until the next acceptance.
REQ-018 In WAIT, on each edge:
- counter=0: capture mul_r into rsp_data and go to RESP;
- otherwise: decrement the counter.
REQ-019 rsp_valid SHALL be 1 exactly in RESP, first rising MUL_LAT cycles after the acceptance edge.
REQ-020 In RESP, rsp_data and rsp_id SHALL stay stable until the edge where rsp_ready=1; at that edge the block SHALL go to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle a response completes; the minimum issue interval is MUL_LAT+2 cycles.
REQ-022 ena=0 SHALL only block new grants; an operation in WAIT or RESP SHALL complete normally.
REQ-023 A request SHALL NOT be dropped or reordered: a requester holding valid while not granted SHALL be granted no later than the second IDLE grant opportunity.
REQ-024 Operand and product widths SHALL pass through unmodified; the block SHALL perform no arithmetic on the data.
REQ-025 Input changes on either requester port while the block is in WAIT or RESP SHALL have no effect.

Reset
REQ-026 While rst_n=0, the block SHALL force:
- state to IDLE and counter to 0;
- last_grant to 1;
- mul_a, mul_b, rsp_data and rsp_id to 0;
- rsp_valid, busy, req0_ready and req1_ready to 0.
REQ-027 Reset asserted in WAIT or RESP SHALL abort the operation; no response for it SHALL ever be issued.
REQ-028 After rst_n is released, the first grant SHALL be possible on the first clock edge.

Verification (N=M=4, MUL_LAT=2, exact-multiplier model on mul_r)
REQ-029 Reset: hold rst_n=0 with random inputs -> every output is 0 and the state is IDLE.
REQ-030 Single request: req0 with a=3, b=2, ena=1 -> req0_ready=1 in the accept cycle; rsp_valid rises 2 cycles after acceptance with rsp_id=0 and rsp_data=6.
REQ-031 Contention: after reset, both valid with req0 (1,2) and req1 (5,3), rsp_ready=1 -> responses (id0, 2) then (id1, 15), accepts spaced 4 cycles apart.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data, rsp_id, mul_a and mul_b stay stable and both ready outputs stay 0.
REQ-033 Enable gating: ena=0 with req1_valid=1 -> req1_ready stays 0; raising ena grants req1 on the next edge.
REQ-034 Reset mid-operation: pulse rst_n low one cycle after acceptance -> rsp_valid never asserts for that request; the next request completes correctly.
